// File: rtl/ahb_sram_slave_if.sv
// AHB slave-port signal bundle: shared address/control/write-data from the
// interconnect plus this slave's select, and the response back to the mux.
interface ahb_sram_slave_if #(
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DATA_BITS = 32
);
  logic                 HSEL;
  logic [ADDR_BITS-1:0] HADDR;
  logic [1:0]           HTRANS;
  logic                 HWRITE;
  logic [2:0]           HSIZE;
  logic [DATA_BITS-1:0] HWDATA;
  logic                 HREADY;
  logic [DATA_BITS-1:0] HRDATA;
  logic                 HREADYOUT;
  logic [1:0]           HRESP;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB SRAM slave: word-organised memory with programmable wait states,
// little-endian byte lanes and a two-cycle ERROR response for illegal sizes.
module ahb_sram_slave #(
  parameter int unsigned ADDR_BITS   = 32,
  parameter int unsigned DATA_BITS   = 32,
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  ahb_sram_slave_if.slave    bus
);
  localparam int unsigned IDX_BITS = $clog2(MEM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LAST,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic [3:0]          lanes_q, lanes_d;
  logic                write_q, write_d;

  logic                accept;
  logic                illegal;
  logic [3:0]          lanes_new;
  logic [31:0]         mem [MEM_WORDS];

  logic unused_bits;
  assign unused_bits = ^{bus.HADDR, bus.HTRANS[0]};

  always_comb begin
    accept  = (state_q inside {S_IDLE, S_LAST, S_ERR2}) &
              bus.HSEL & bus.HREADY & bus.HTRANS[1];
    illegal = (bus.HSIZE > 3'd2) ||
              (bus.HSIZE == 3'd1 && bus.HADDR[0]) ||
              (bus.HSIZE == 3'd2 && bus.HADDR[1:0] != 2'b00);
    case (bus.HSIZE)
      3'd0:    lanes_new = 4'b0001 << bus.HADDR[1:0];
      3'd1:    lanes_new = bus.HADDR[1] ? 4'b1100 : 4'b0011;
      default: lanes_new = 4'b1111;
    endcase

    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lanes_d = lanes_q;
    write_d = write_q;
    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_LAST;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        // IDLE, LAST and ERR2 all take a new address phase the same way
        state_d = S_IDLE;
        if (accept) begin
          idx_d   = bus.HADDR[IDX_BITS+1:2];
          lanes_d = lanes_new;
          write_d = bus.HWRITE;
          if (illegal) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end else begin
            state_d = S_LAST;
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      lanes_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lanes_q <= lanes_d;
      write_q <= write_d;
    end
  end

  // Reset on the LAST edge suppresses the commit of an in-flight write
  always_ff @(posedge HCLK) begin
    if (HRESETn && state_q == S_LAST && write_q) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lanes_q[i]) mem[idx_q][8*i +: 8] <= bus.HWDATA[8*i +: 8];
      end
    end
  end

  always_comb begin
    bus.HREADYOUT = state_q inside {S_IDLE, S_LAST, S_ERR2};
    bus.HRESP     = (state_q inside {S_ERR1, S_ERR2}) ? 2'b01 : 2'b00;
    bus.HRDATA    = (state_q == S_LAST && !write_q) ? mem[idx_q] : '0;
  end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one instance with two wait states and
// one zero-wait instance driven from a per-cycle vector table.
module tb_ahb_sram_slave;
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10, T_SEQ = 2'b11;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ahb_sram_slave_if #(.ADDR_BITS(32), .DATA_BITS(32)) if_a ();
  ahb_sram_slave_if #(.ADDR_BITS(32), .DATA_BITS(32)) if_b ();

  // Single slave on the bus: bus-level ready is this slave's ready
  assign if_a.HREADY = if_a.HREADYOUT;
  assign if_b.HREADY = if_b.HREADYOUT;

  ahb_sram_slave #(.ADDR_BITS(32), .DATA_BITS(32), .MEM_WORDS(1024), .WAIT_STATES(2))
    u_dut_ws2 (.HCLK(clk), .HRESETn(rstn), .bus(if_a));
  ahb_sram_slave #(.ADDR_BITS(32), .DATA_BITS(32), .MEM_WORDS(1024), .WAIT_STATES(0))
    u_dut_ws0 (.HCLK(clk), .HRESETn(rstn), .bus(if_b));

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_ready;
    logic [1:0]  exp_resp;
    logic        chk_rd;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(logic sel, logic [1:0] trans, logic wr, logic [2:0] size,
                              logic [31:0] addr, logic [31:0] wdata, logic exp_ready,
                              logic [1:0] exp_resp, logic chk_rd, logic [31:0] exp_rdata);
    vec_t v;
    v.sel = sel; v.trans = trans; v.wr = wr; v.size = size; v.addr = addr;
    v.wdata = wdata; v.exp_ready = exp_ready; v.exp_resp = exp_resp;
    v.chk_rd = chk_rd; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive_a(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    if_a.HSEL = sel; if_a.HTRANS = trans; if_a.HWRITE = wr;
    if_a.HSIZE = size; if_a.HADDR = addr; if_a.HWDATA = wdata;
  endtask

  task automatic drive_b(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    if_b.HSEL = sel; if_b.HTRANS = trans; if_b.HWRITE = wr;
    if_b.HSIZE = size; if_b.HADDR = addr; if_b.HWDATA = wdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic rdy, input logic [1:0] resp,
                       input logic [31:0] rdata);
    chk({tag, ".ready"}, 32'(if_a.HREADYOUT), 32'(rdy));
    chk({tag, ".resp"},  32'(if_a.HRESP),     32'(resp));
    chk({tag, ".rdata"}, if_a.HRDATA,         rdata);
  endtask

  task automatic chk_b(input string tag, input logic rdy, input logic [1:0] resp,
                       input logic [31:0] rdata);
    chk({tag, ".ready"}, 32'(if_b.HREADYOUT), 32'(rdy));
    chk({tag, ".resp"},  32'(if_b.HRESP),     32'(resp));
    chk({tag, ".rdata"}, if_b.HRDATA,         rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with NONSEQ traffic on both buses
    rstn = 1'b0;
    drive_a(1'b1, T_NS, 1'b1, 3'd2, 32'h10, 32'h12345678);
    drive_b(1'b1, T_NS, 1'b1, 3'd2, 32'h40, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_a($sformatf("rst_a[%0d]", i), 1'b1, 2'b00, 32'h0);
      chk_b($sformatf("rst_b[%0d]", i), 1'b1, 2'b00, 32'h0);
    end
    drive_a(1'b0, T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0);
    drive_b(1'b0, T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0);
    rstn = 1'b1;
    step();

    // Zero-wait instance: byte lanes, illegal transfers, ignored traffic, back-to-back
    tbl[0]  = mk(1, T_NS,   1, 3'd2, 32'h20, 32'h0,        1, 2'b00, 1, 32'h0);
    tbl[1]  = mk(1, T_NS,   1, 3'd0, 32'h22, 32'h11223344, 1, 2'b00, 0, 32'h0);
    tbl[2]  = mk(1, T_NS,   1, 3'd1, 32'h20, 32'h00AA0000, 1, 2'b00, 0, 32'h0);
    tbl[3]  = mk(1, T_NS,   0, 3'd2, 32'h20, 32'h0000BBCC, 1, 2'b00, 0, 32'h0);
    tbl[4]  = mk(0, T_IDLE, 0, 3'd2, 32'h0,  32'h0,        1, 2'b00, 1, 32'h11AABBCC);
    tbl[5]  = mk(1, T_NS,   0, 3'd2, 32'h21, 32'h0,        1, 2'b00, 1, 32'h0);
    tbl[6]  = mk(0, T_IDLE, 0, 3'd0, 32'h0,  32'h0,        0, 2'b01, 1, 32'h0);
    tbl[7]  = mk(1, T_NS,   1, 3'd3, 32'h20, 32'h0,        1, 2'b01, 1, 32'h0);
    tbl[8]  = mk(0, T_IDLE, 0, 3'd0, 32'h0,  32'hFFFFFFFF, 0, 2'b01, 1, 32'h0);
    tbl[9]  = mk(1, T_NS,   0, 3'd2, 32'h20, 32'h0,        1, 2'b01, 1, 32'h0);
    tbl[10] = mk(1, T_BUSY, 0, 3'd2, 32'h20, 32'h0,        1, 2'b00, 1, 32'h11AABBCC);
    tbl[11] = mk(1, T_NS,   1, 3'd2, 32'h24, 32'h0,        1, 2'b00, 1, 32'h0);
    tbl[12] = mk(0, T_NS,   0, 3'd2, 32'h20, 32'hCAFEF00D, 1, 2'b00, 0, 32'h0);
    tbl[13] = mk(1, T_NS,   0, 3'd2, 32'h20, 32'h0,        1, 2'b00, 1, 32'h0);
    tbl[14] = mk(1, T_SEQ,  0, 3'd2, 32'h24, 32'h0,        1, 2'b00, 1, 32'h11AABBCC);
    tbl[15] = mk(1, T_NS,   0, 3'd2, 32'h20, 32'h0,        1, 2'b00, 1, 32'hCAFEF00D);
    tbl[16] = mk(0, T_IDLE, 0, 3'd0, 32'h0,  32'h0,        1, 2'b00, 1, 32'h11AABBCC);
    tbl[17] = mk(0, T_IDLE, 0, 3'd0, 32'h0,  32'h0,        1, 2'b00, 1, 32'h0);

    for (int i = 0; i < 18; i++) begin
      drive_b(tbl[i].sel, tbl[i].trans, tbl[i].wr, tbl[i].size, tbl[i].addr, tbl[i].wdata);
      chk($sformatf("ws0[%0d].ready", i), 32'(if_b.HREADYOUT), 32'(tbl[i].exp_ready));
      chk($sformatf("ws0[%0d].resp", i),  32'(if_b.HRESP),     32'(tbl[i].exp_resp));
      if (tbl[i].chk_rd) chk($sformatf("ws0[%0d].rdata", i), if_b.HRDATA, tbl[i].exp_rdata);
      step();
    end

    // Two-wait-state instance: write then read of 0x10, each data phase 0,0,1
    drive_a(1'b1, T_NS, 1'b1, 3'd2, 32'h10, 32'h0);
    chk_a("ws2_wr_addr", 1'b1, 2'b00, 32'h0);
    step();
    drive_a(1'b0, T_IDLE, 1'b0, 3'd0, 32'h0, 32'hDEADBEEF);
    chk_a("ws2_wr_dp0", 1'b0, 2'b00, 32'h0);
    step();
    chk_a("ws2_wr_dp1", 1'b0, 2'b00, 32'h0);
    step();
    drive_a(1'b1, T_NS, 1'b0, 3'd2, 32'h10, 32'hDEADBEEF);
    chk("ws2_wr_dp2.ready", 32'(if_a.HREADYOUT), 32'd1);
    chk("ws2_wr_dp2.resp",  32'(if_a.HRESP),     32'd0);
    step();
    drive_a(1'b0, T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0);
    chk_a("ws2_rd_dp0", 1'b0, 2'b00, 32'h0);
    step();
    chk_a("ws2_rd_dp1", 1'b0, 2'b00, 32'h0);
    step();
    chk_a("ws2_rd_dp2", 1'b1, 2'b00, 32'hDEADBEEF);
    step();
    chk_a("ws2_after", 1'b1, 2'b00, 32'h0);

    // Reset landing on the LAST edge of a write leaves the old word intact
    drive_b(1'b1, T_NS, 1'b1, 3'd2, 32'h40, 32'h0);
    step();
    drive_b(1'b1, T_NS, 1'b1, 3'd2, 32'h40, 32'h01020304);
    step();
    drive_b(1'b0, T_IDLE, 1'b0, 3'd0, 32'h0, 32'h5555AAAA);
    chk("rstwr_last.ready", 32'(if_b.HREADYOUT), 32'd1);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk_b("rstwr_post", 1'b1, 2'b00, 32'h0);
    drive_b(1'b1, T_NS, 1'b0, 3'd2, 32'h40, 32'h0);
    step();
    drive_b(1'b0, T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0);
    chk_b("rstwr_read", 1'b1, 2'b00, 32'h01020304);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
